// File: rtl/state_sequencer.sv
// Multi-cycle CPU state register with control-enable decode, sticky halt,
// illegal-state recovery and a retired-instruction counter.
module state_sequencer #(
  parameter int COUNT_W = 16
) (
  input  logic               CLK,
  input  logic               Reset,
  input  logic [2:0]         n_state,
  input  logic [5:0]         Opcode,
  output logic [2:0]         cur_state,
  output logic               IRWre,
  output logic               PCWre,
  output logic               RegWre,
  output logic               mRD,
  output logic               mWR,
  output logic               halted,
  output logic               state_err,
  output logic [COUNT_W-1:0] instr_count
);

  typedef enum logic [2:0] {
    S_IF  = 3'b000,
    S_ID  = 3'b001,
    S_EXE = 3'b010,
    S_WB  = 3'b011,
    S_MEM = 3'b100
  } state_t;

  localparam logic [5:0] OP_SW   = 6'b110000;
  localparam logic [5:0] OP_LW   = 6'b110001;
  localparam logic [5:0] OP_HALT = 6'b111111;

  state_t               state_reg;
  logic                 halted_reg;
  logic                 state_err_reg;
  logic [COUNT_W-1:0]   count_reg;

  logic next_legal;
  logic next_is_if;
  logic halt_now;
  logic retire;

  assign next_legal = (n_state <= 3'b100);
  assign next_is_if = next_legal && (n_state == S_IF);
  assign halt_now   = !halted_reg && (state_reg == S_ID) && (Opcode == OP_HALT);
  // The halt instruction retires on its own edge even if next-state logic disagrees.
  assign retire     = !halted_reg && (state_reg != S_IF) && (next_is_if || halt_now);

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state_reg     <= S_IF;
      halted_reg    <= 1'b0;
      state_err_reg <= 1'b0;
      count_reg     <= '0;
    end else begin
      state_err_reg <= 1'b0;
      if (halted_reg || halt_now) begin
        state_reg <= S_IF;
      end else if (!next_legal) begin
        state_reg     <= S_IF;
        state_err_reg <= 1'b1;
      end else begin
        state_reg <= state_t'(n_state);
      end
      if (halt_now) begin
        halted_reg <= 1'b1;
      end
      if (retire) begin
        count_reg <= count_reg + {{(COUNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

  // Enables decode from the registered state; IRWre ignores Opcode since it is stale in IF.
  assign IRWre  = (state_reg == S_IF) && !halted_reg;
  assign RegWre = (state_reg == S_WB) && !halted_reg;
  assign mRD    = (state_reg == S_MEM) && (Opcode == OP_LW) && !halted_reg;
  assign mWR    = (state_reg == S_MEM) && (Opcode == OP_SW) && !halted_reg;
  assign PCWre  = next_is_if && (state_reg != S_IF) && !halted_reg &&
                  !((state_reg == S_ID) && (Opcode == OP_HALT));

  assign cur_state   = state_reg;
  assign halted      = halted_reg;
  assign state_err   = state_err_reg;
  assign instr_count = count_reg;

endmodule

// File: tb/tb_state_sequencer.sv
// Table-driven bench for state_sequencer: each row drives inputs between
// edges, checks outputs 1 time unit later, then lets the next edge load n_state.
module tb_state_sequencer;

  localparam int CW = 4;

  logic          clk;
  logic          rst;
  logic [2:0]    n_state;
  logic [5:0]    opcode;
  logic [2:0]    cur_state;
  logic          irwre, pcwre, regwre, mrd, mwr, halted, state_err;
  logic [CW-1:0] instr_count;

  state_sequencer #(.COUNT_W(CW)) dut (
    .CLK(clk), .Reset(rst), .n_state(n_state), .Opcode(opcode),
    .cur_state(cur_state), .IRWre(irwre), .PCWre(pcwre), .RegWre(regwre),
    .mRD(mrd), .mWR(mwr), .halted(halted), .state_err(state_err),
    .instr_count(instr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic          rst;
    logic [2:0]    ns;
    logic [5:0]    op;
    logic [2:0]    cs;
    logic          ir, pc, rw, rd, wr, h, err;
    logic [CW-1:0] cnt;
  } vec_t;

  int n_cmp = 0;
  int n_bad = 0;
  int row   = 0;

  function automatic vec_t mk(input logic r, input logic [2:0] ns, input logic [5:0] op,
                              input logic [2:0] cs, input logic ir, input logic pc,
                              input logic rw, input logic rd, input logic wr,
                              input logic h, input logic err, input int cnt);
    vec_t v;
    v.rst = r; v.ns = ns; v.op = op; v.cs = cs;
    v.ir = ir; v.pc = pc; v.rw = rw; v.rd = rd; v.wr = wr;
    v.h = h; v.err = err; v.cnt = CW'(cnt);
    return v;
  endfunction

  task automatic cmp(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s row %0d: got %0h, expected %0h", name, row, act, exp);
    end
  endtask

  task automatic apply(input vec_t v);
    @(negedge clk);
    rst = v.rst; n_state = v.ns; opcode = v.op;
    #1;
    cmp("cur_state",   int'(cur_state),   int'(v.cs));
    cmp("IRWre",       int'(irwre),       int'(v.ir));
    cmp("PCWre",       int'(pcwre),       int'(v.pc));
    cmp("RegWre",      int'(regwre),      int'(v.rw));
    cmp("mRD",         int'(mrd),         int'(v.rd));
    cmp("mWR",         int'(mwr),         int'(v.wr));
    cmp("halted",      int'(halted),      int'(v.h));
    cmp("state_err",   int'(state_err),   int'(v.err));
    cmp("instr_count", int'(instr_count), int'(v.cnt));
    $display("row %0d: rst=%0b ns=%03b op=%06b -> cs=%03b ir=%0b pc=%0b rw=%0b rd=%0b wr=%0b h=%0b err=%0b cnt=%0d",
             row, v.rst, v.ns, v.op, cur_state, irwre, pcwre, regwre, mrd, mwr,
             halted, state_err, instr_count);
    row++;
  endtask

  localparam logic [5:0] ADD = 6'b000000;
  localparam logic [5:0] LW  = 6'b110001;
  localparam logic [5:0] SW  = 6'b110000;
  localparam logic [5:0] HLT = 6'b111111;

  vec_t tbl[30];

  initial begin
    rst = 1'b1; n_state = 3'b000; opcode = ADD;

    //             rst ns      op    cs     ir pc rw rd wr h  err cnt
    tbl[0]  = mk(1, 3'b001, ADD, 3'b000, 1, 0, 0, 0, 0, 0, 0, 0);
    // add: IF ID EXE WB
    tbl[1]  = mk(0, 3'b001, ADD, 3'b000, 1, 0, 0, 0, 0, 0, 0, 0);
    tbl[2]  = mk(0, 3'b010, ADD, 3'b001, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[3]  = mk(0, 3'b011, ADD, 3'b010, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[4]  = mk(0, 3'b000, ADD, 3'b011, 0, 1, 1, 0, 0, 0, 0, 0);
    // lw: IF ID EXE MEM WB
    tbl[5]  = mk(0, 3'b001, LW,  3'b000, 1, 0, 0, 0, 0, 0, 0, 1);
    tbl[6]  = mk(0, 3'b010, LW,  3'b001, 0, 0, 0, 0, 0, 0, 0, 1);
    tbl[7]  = mk(0, 3'b100, LW,  3'b010, 0, 0, 0, 0, 0, 0, 0, 1);
    tbl[8]  = mk(0, 3'b011, LW,  3'b100, 0, 0, 0, 1, 0, 0, 0, 1);
    tbl[9]  = mk(0, 3'b000, LW,  3'b011, 0, 1, 1, 0, 0, 0, 0, 1);
    // sw: IF ID EXE MEM
    tbl[10] = mk(0, 3'b001, SW,  3'b000, 1, 0, 0, 0, 0, 0, 0, 2);
    tbl[11] = mk(0, 3'b010, SW,  3'b001, 0, 0, 0, 0, 0, 0, 0, 2);
    tbl[12] = mk(0, 3'b100, SW,  3'b010, 0, 0, 0, 0, 0, 0, 0, 2);
    tbl[13] = mk(0, 3'b000, SW,  3'b100, 0, 1, 0, 0, 1, 0, 0, 2);
    // IF->IF loop does not retire
    tbl[14] = mk(0, 3'b000, ADD, 3'b000, 1, 0, 0, 0, 0, 0, 0, 3);
    tbl[15] = mk(0, 3'b001, ADD, 3'b000, 1, 0, 0, 0, 0, 0, 0, 3);
    // illegal 110 and 111 from EXE
    tbl[16] = mk(0, 3'b010, ADD, 3'b001, 0, 0, 0, 0, 0, 0, 0, 3);
    tbl[17] = mk(0, 3'b110, ADD, 3'b010, 0, 0, 0, 0, 0, 0, 0, 3);
    tbl[18] = mk(0, 3'b001, ADD, 3'b000, 1, 0, 0, 0, 0, 0, 1, 3);
    tbl[19] = mk(0, 3'b010, ADD, 3'b001, 0, 0, 0, 0, 0, 0, 0, 3);
    tbl[20] = mk(0, 3'b111, ADD, 3'b010, 0, 0, 0, 0, 0, 0, 0, 3);
    tbl[21] = mk(0, 3'b000, ADD, 3'b000, 1, 0, 0, 0, 0, 0, 1, 3);
    // halt in ID, then n_state=001 for five cycles
    tbl[22] = mk(0, 3'b001, ADD, 3'b000, 1, 0, 0, 0, 0, 0, 0, 3);
    tbl[23] = mk(0, 3'b000, HLT, 3'b001, 0, 0, 0, 0, 0, 0, 0, 3);
    tbl[24] = mk(0, 3'b001, ADD, 3'b000, 0, 0, 0, 0, 0, 1, 0, 4);
    tbl[25] = mk(0, 3'b001, LW,  3'b000, 0, 0, 0, 0, 0, 1, 0, 4);
    tbl[26] = mk(0, 3'b001, SW,  3'b000, 0, 0, 0, 0, 0, 1, 0, 4);
    tbl[27] = mk(0, 3'b001, HLT, 3'b000, 0, 0, 0, 0, 0, 1, 0, 4);
    tbl[28] = mk(0, 3'b001, ADD, 3'b000, 0, 0, 0, 0, 0, 1, 0, 4);
    // reset between edges clears halt and count immediately
    tbl[29] = mk(1, 3'b001, ADD, 3'b000, 1, 0, 0, 0, 0, 0, 0, 0);

    for (int i = 0; i < 30; i++) apply(tbl[i]);

    // 16 two-cycle instructions on a 4-bit counter: 15 -> 0 wrap
    for (int i = 0; i < 16; i++) begin
      apply(mk(0, 3'b001, ADD, 3'b000, 1, 0, 0, 0, 0, 0, 0, i));
      apply(mk(0, 3'b000, ADD, 3'b001, 0, 1, 0, 0, 0, 0, 0, i));
    end
    apply(mk(0, 3'b001, ADD, 3'b000, 1, 0, 0, 0, 0, 0, 0, 0));
    apply(mk(0, 3'b000, ADD, 3'b001, 0, 1, 0, 0, 0, 0, 0, 0));

    // reset asserted in EXE abandons the instruction and clears the count
    apply(mk(0, 3'b001, ADD, 3'b000, 1, 0, 0, 0, 0, 0, 0, 1));
    apply(mk(0, 3'b010, ADD, 3'b001, 0, 0, 0, 0, 0, 0, 0, 1));
    apply(mk(0, 3'b011, ADD, 3'b010, 0, 0, 0, 0, 0, 0, 0, 1));
    apply(mk(1, 3'b011, ADD, 3'b000, 1, 0, 0, 0, 0, 0, 0, 0));
    // first post-release edge loads n_state directly (IF -> MEM)
    apply(mk(0, 3'b100, LW,  3'b000, 1, 0, 0, 0, 0, 0, 0, 0));
    apply(mk(0, 3'b000, LW,  3'b100, 0, 1, 0, 1, 0, 0, 0, 0));
    apply(mk(0, 3'b001, ADD, 3'b000, 1, 0, 0, 0, 0, 0, 0, 1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/state_sequencer.md
STATE_SEQUENCER -- requirements
Module: state_sequencer

Interface
REQ-001 The block SHALL have parameter COUNT_W, default 16, giving the width of the retired-instruction counter.
REQ-002 The block SHALL have port CLK, input, 1 bit, the single system clock, rising-edge active.
REQ-003 The block SHALL have port Reset, input, 1 bit, an asynchronous active-high reset.
REQ-004 The block SHALL have port n_state, input, 3 bits, the next state from the next-state logic.
REQ-005 The block SHALL have port Opcode, input, 6 bits, the opcode field of the instruction register.
REQ-006 The block SHALL have port cur_state, output, 3 bits, the registered current state, which is fed back to the next-state logic.
REQ-007 The block SHALL have port IRWre, output, 1 bit, the instruction-register write enable.
REQ-008 The block SHALL have port PCWre, output, 1 bit, the PC write enable.
REQ-009 The block SHALL have port RegWre, output, 1 bit, the register-file write enable.
REQ-010 The block SHALL have ports mRD and mWR, outputs, 1 bit each, the data-memory read and write strobes.
REQ-011 The block SHALL have port halted, output, 1 bit, a sticky halt flag.
REQ-012 The block SHALL have port state_err, output, 1 bit, a one-cycle pulse flagging an illegal n_state.
REQ-013 The block SHALL have port instr_count, output, COUNT_W bits, the count of retired instructions.

Function
REQ-014 State encodings SHALL be: sIF=000, sID=001, sEXE=010, sWB=011, sMEM=100; the codes 101, 110 and 111 are illegal.
REQ-015 On each rising CLK, cur_state SHALL load n_state, giving exactly one cycle of latency from n_state to cur_state.
REQ-016 If n_state is illegal, cur_state SHALL load sIF and state_err SHALL be 1 for the following cycle only; instr_count SHALL NOT increment.
REQ-017 IRWre SHALL equal (cur_state==sIF) && !halted, and SHALL be decoded from state only, because Opcode is stale in sIF.
REQ-018 RegWre SHALL equal (cur_state==sWB) && !halted.
REQ-019 mRD SHALL equal (cur_state==sMEM && Opcode==110001, lw).
REQ-020 mWR SHALL equal (cur_state==sMEM && Opcode==110000, sw).
REQ-021 PCWre SHALL equal (n_state==sIF) && (cur_state!=sIF) && !halted && !(cur_state==sID && Opcode==111111), so the PC updates once, in the last cycle of each instruction.
REQ-022 All enable outputs (IRWre, PCWre, RegWre, mRD, mWR) SHALL be combinational from registered state and inputs, with no added latency.
REQ-023 halted SHALL be set at the rising edge where cur_state==sID and Opcode==111111 (halt), and SHALL stay set until Reset.
REQ-024 While halted=1: cur_state SHALL be held at sIF regardless of n_state; IRWre, PCWre, RegWre, mRD and mWR SHALL all be 0; instr_count SHALL be frozen.
REQ-025 instr_count SHALL increment by 1 on each rising edge where cur_state!=sIF, the loaded next state is a legal sIF, and halted=0.
REQ-026 The halt instruction itself SHALL count as retired, incrementing instr_count on its sID-to-sIF edge.
REQ-027 instr_count SHALL wrap from 2^COUNT_W-1 to 0 with no flag.
REQ-028 A single-cycle sIF-to-sIF loop, i.e. n_state==sIF while cur_state==sIF, SHALL NOT increment instr_count.

Reset
REQ-029 Reset=1 SHALL immediately, without waiting for CLK, force cur_state=sIF, halted=0, state_err=0 and instr_count=0.
REQ-030 Combinational outputs SHALL follow from the reset state: IRWre=1, PCWre=0, RegWre=0, mRD=0, mWR=0.
REQ-031 Reset asserted mid-instruction (any state) SHALL abandon that instruction with no count increment; the first post-release edge SHALL load n_state normally.
REQ-032 Reset SHALL clear halted and state_err with priority over any simultaneous set condition.

Verification
REQ-033 The bench SHALL check reset: assert Reset between edges -> cur_state=000, instr_count=0 and IRWre=1 immediately; release -> normal sequencing.
REQ-034 The bench SHALL check an add instruction: drive n_state 001,010,011,000 with Opcode=000000 -> IRWre=1 only in sIF, RegWre=1 only in sWB, PCWre=1 only in the sWB cycle, instr_count 0->1.
REQ-035 The bench SHALL check lw and sw: lw path IF,ID,EXE,MEM,WB -> mRD=1 in MEM only; sw path IF,ID,EXE,MEM -> mWR=1 in MEM and PCWre=1 in that cycle, with 2 retired instructions total.
REQ-036 The bench SHALL check halt: Opcode=111111 in sID -> halted=1 next edge with instr_count incremented; then drive n_state=001 for 5 cycles -> cur_state stays 000, all enables 0, instr_count unchanged.
REQ-037 The bench SHALL check an illegal state: n_state=110 from sEXE -> cur_state=000 and state_err=1 for exactly one cycle, with no increment.
REQ-038 The bench SHALL check wrap and mid-operation reset: with COUNT_W=4 run 16 instructions -> instr_count 15->0; then assert Reset in sEXE -> cur_state=000, count 0.
